ucsbece154a_imem_encoder: RTL and testbench
===========================================

// Module: ucsbece154a_imem_encoder
// PURPOSE
// Inverse of the single-cycle controller's decode path. Accepts symbolic instruction requests
// (class, ALU op, registers, immediate), encodes each one into a 32-bit RV32I word and writes
// it to sequential instruction-memory addresses. It is the program-load front end used by the
// bench and the boot path. Supported subset: lw, sw, R-type, beq, I-type ALU, jal, lui.
// PARAMETERS
// ADDR_W     6   word-address width; capacity 2**ADDR_W words
// BASE_ADDR  0   first word address written after reset/clear
// PORTS
// clk      in   1       rising-edge clock
// reset    in   1       asynchronous, active-high reset
// valid_i  in   1       request valid
// ready_o  out  1       encoder can accept; a transfer occurs when valid_i & ready_o
// kind_i   in   3       0 lw, 1 sw, 2 R-type, 3 beq, 4 I-ALU, 5 jal, 6 lui, 7 illegal
// alu_i    in   3       0 add, 1 sub, 2 and, 3 or, 5 slt (used only by R-type and I-ALU)
// rd_i     in   5       destination register
// rs1_i    in   5       source register 1
// rs2_i    in   5       source register 2
// imm_i    in   32      byte offset or immediate; lui uses imm_i[31:12]
// clear_i  in   1       synchronous restart: address to BASE_ADDR, count 0, error cleared
// we_o     out  1       instruction-memory write strobe
// waddr_o  out  ADDR_W  word address of the write
// wdata_o  out  32      encoded instruction
// count_o  out  ADDR_W+1  number of words written since reset or clear
// full_o   out  1       count_o == 2**ADDR_W
// error_o  out  1       sticky; set by an illegal request
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately): state IDLE; we_o=0; wdata_o=0;
//   waddr_o=BASE_ADDR; count_o=0; error_o=0; ready_o=1.
// - FSM IDLE -> ENC -> WR -> IDLE.
//   IDLE: ready_o = ~full_o. On a transfer, register the fields and move to ENC.
//   ENC: register the encoded word into wdata_o and move to WR.
//   WR: we_o=1 for exactly this cycle. At the edge, waddr_o += 1 (wraps modulo 2**ADDR_W)
//   and count_o += 1. Return to IDLE.
// - Timing: transfer at edge N gives we_o high in the cycle after edge N+1. ready_o is low in
//   ENC and WR. Maximum throughput is one word per 3 cycles.
// - clear_i is sampled only in IDLE and has priority over valid_i; no transfer occurs that cycle.
// - Full: when full_o=1, ready_o=0 and valid_i is ignored until clear_i or reset.
// - Encoding:
//   - Opcodes: lw 0000011 (f3 010); sw 0100011 (f3 010); R 0110011; I-ALU 0010011;
//     beq 1100011 (f3 000); jal 1101111; lui 0110111.
//   - ALU funct3: add/sub 000, slt 010, or 110, and 111. funct7 is 0100000 only for R-type sub,
//     otherwise 0.
//   - Immediate formats: I imm[11:0]; S imm[11:5]|imm[4:0];
//     B imm[12|10:5] / imm[4:1|11]; J imm[20|10:1|11|19:12]; U imm[31:12].
//   - Upper immediate bits beyond each field are truncated without checks.
// - Illegal requests: kind_i=7; alu_i not in {0,1,2,3,5} for R-type or I-ALU; sub with I-ALU;
//   beq or jal with imm_i[0]=1. The handshake completes normally, error_o is set, and ENC
//   returns to IDLE with no WR: no write occurs and the address and count are unchanged.
// - Reset asserted in ENC or WR: we_o drops immediately and the pending word is discarded.
// TESTING
// 1. Reset, then R add rd=5 rs1=6 rs2=7 -> one we_o pulse, waddr_o=0, wdata_o=0x007302B3,
//    count_o=1.
// 2. R sub rd=1 rs1=2 rs2=3, then lw rd=4 rs1=2 imm=8 -> 0x403100B3 @1, 0x00812203 @2,
//    ready_o low for exactly 2 cycles after each transfer.
// 3. beq rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; jal rd=1 imm=16 -> 0x010000EF;
//    lui rd=3 imm=0x12345000 -> 0x123451B7.
// 4. beq with imm=3, and kind_i=7 -> error_o=1 (sticky), no we_o, count_o unchanged;
//    clear_i -> error_o=0.
// 5. ADDR_W=2: 4 writes -> full_o=1, ready_o=0, a 5th valid_i is ignored;
//    clear_i -> count_o=0, next write goes to address 0.
// 6. Assert reset during ENC -> we_o stays 0, all outputs at reset values,
//    the next request is written at BASE_ADDR.

Source files
------------

// File: rtl/ucsbece154a_imem_encoder.sv
// Encodes symbolic RV32I requests (lw/sw/R/beq/I-ALU/jal/lui) and writes them to sequential imem words.
// Three cycles per word (IDLE->ENC->WR), ready_o low in ENC/WR and while full; illegal requests only set error_o.
module ucsbece154a_imem_encoder #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        kind_i,
  input  logic [2:0]        alu_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  input  logic              clear_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              error_o
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] K_LW   = 3'd0;
  localparam logic [2:0] K_SW   = 3'd1;
  localparam logic [2:0] K_R    = 3'd2;
  localparam logic [2:0] K_BEQ  = 3'd3;
  localparam logic [2:0] K_IALU = 3'd4;
  localparam logic [2:0] K_JAL  = 3'd5;
  localparam logic [2:0] K_LUI  = 3'd6;

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_AND = 3'd2;
  localparam logic [2:0] A_OR  = 3'd3;
  localparam logic [2:0] A_SLT = 3'd5;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_t;

  state_t      state, state_n;
  req_t        req;
  logic        take;
  logic        do_clear;
  logic [2:0]  alu_f3;
  logic        alu_ok;
  logic [6:0]  r_f7;
  logic [31:0] enc_word;
  logic        illegal;

  assign full_o = (count_o == CAP);

  // ALU op to funct3; unsupported codes flag the request illegal for R/I-ALU
  always_comb begin
    alu_f3 = 3'b000;
    alu_ok = 1'b1;
    case (req.alu)
      A_ADD, A_SUB: alu_f3 = 3'b000;
      A_AND:        alu_f3 = 3'b111;
      A_OR:         alu_f3 = 3'b110;
      A_SLT:        alu_f3 = 3'b010;
      default:      alu_ok = 1'b0;
    endcase
    r_f7 = (req.alu == A_SUB) ? 7'b0100000 : 7'b0000000;
  end

  always_comb begin
    enc_word = 32'h0;
    illegal  = 1'b0;
    case (req.kind)
      K_LW:   enc_word = {req.imm[11:0], req.rs1, 3'b010, req.rd, OP_LW};
      K_SW:   enc_word = {req.imm[11:5], req.rs2, req.rs1, 3'b010, req.imm[4:0], OP_SW};
      K_R: begin
        enc_word = {r_f7, req.rs2, req.rs1, alu_f3, req.rd, OP_R};
        illegal  = ~alu_ok;
      end
      K_BEQ: begin
        enc_word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, 3'b000,
                    req.imm[4:1], req.imm[11], OP_BEQ};
        illegal  = req.imm[0];
      end
      K_IALU: begin
        enc_word = {req.imm[11:0], req.rs1, alu_f3, req.rd, OP_IALU};
        illegal  = ~alu_ok | (req.alu == A_SUB);
      end
      K_JAL: begin
        enc_word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, OP_JAL};
        illegal  = req.imm[0];
      end
      K_LUI:   enc_word = {req.imm[31:12], req.rd, OP_LUI};
      default: illegal  = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    ready_o  = 1'b0;
    we_o     = 1'b0;
    take     = 1'b0;
    do_clear = 1'b0;
    case (state)
      S_IDLE: begin
        ready_o = ~full_o;
        // clear wins over a simultaneous request; nothing is accepted that cycle
        if (clear_i) begin
          do_clear = 1'b1;
        end else if (valid_i && !full_o) begin
          take    = 1'b1;
          state_n = S_ENC;
        end
      end
      S_ENC:   state_n = illegal ? S_IDLE : S_WR;
      S_WR: begin
        we_o    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      req     <= '0;
      wdata_o <= 32'h0;
      waddr_o <= BASE;
      count_o <= '0;
      error_o <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        req <= '{kind: kind_i, alu: alu_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i, imm: imm_i};
      end
      if (state == S_ENC) begin
        if (illegal) begin
          error_o <= 1'b1;
        end else begin
          wdata_o <= enc_word;
        end
      end
      if (state == S_WR) begin
        waddr_o <= waddr_o + 1'b1;
        count_o <= count_o + 1'b1;
      end
      if (do_clear) begin
        waddr_o <= BASE;
        count_o <= '0;
        error_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154a_imem_encoder.sv
// Bench for the imem encoder: directed cases plus random requests against a field-arithmetic model.
module tb_ucsbece154a_imem_encoder;

  localparam int AW  = 2;
  localparam int CAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  kind_i;
  logic [2:0]  alu_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i;
  logic        clear_i;
  logic        we_o;
  logic [AW-1:0] waddr_o;
  logic [31:0] wdata_o;
  logic [AW:0] count_o;
  logic        full_o;
  logic        error_o;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_addr = 0;
  int m_cnt  = 0;
  int m_err  = 0;

  ucsbece154a_imem_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .kind_i(kind_i), .alu_i(alu_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .imm_i(imm_i), .clear_i(clear_i), .we_o(we_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .count_o(count_o), .full_o(full_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: places each field at its bit position with plain arithmetic
  function automatic void ref_encode(input bit [31:0] k, a, rd, rs1, rs2, imm,
                                     output bit ill, output bit [31:0] w);
    bit [31:0] f3;
    bit        alu_bad;
    alu_bad = 1'b0;
    f3      = 32'd0;
    case (a)
      32'd0, 32'd1: f3 = 32'd0;
      32'd2:        f3 = 32'd7;
      32'd3:        f3 = 32'd6;
      32'd5:        f3 = 32'd2;
      default:      alu_bad = 1'b1;
    endcase
    ill = 1'b0;
    w   = 32'd0;
    case (k)
      32'd0: w = 32'h03 + (rd << 7) + (32'd2 << 12) + (rs1 << 15) + ((imm & 32'hFFF) << 20);
      32'd1: w = 32'h23 + ((imm & 32'd31) << 7) + (32'd2 << 12) + (rs1 << 15) + (rs2 << 20)
                 + (((imm >> 5) & 32'd127) << 25);
      32'd2: begin
        ill = alu_bad;
        w = 32'h33 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
            + ((a == 32'd1) ? 32'h4000_0000 : 32'd0);
      end
      32'd3: begin
        ill = imm[0];
        w = 32'h63 + (((imm >> 11) & 32'd1) << 7) + (((imm >> 1) & 32'd15) << 8)
            + (rs1 << 15) + (rs2 << 20) + (((imm >> 5) & 32'd63) << 25)
            + (((imm >> 12) & 32'd1) << 31);
      end
      32'd4: begin
        ill = alu_bad || (a == 32'd1);
        w = 32'h13 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 32'hFFF) << 20);
      end
      32'd5: begin
        ill = imm[0];
        w = 32'h6F + (rd << 7) + (((imm >> 12) & 32'd255) << 12) + (((imm >> 11) & 32'd1) << 20)
            + (((imm >> 1) & 32'd1023) << 21) + (((imm >> 20) & 32'd1) << 31);
      end
      32'd6: w = 32'h37 + (rd << 7) + (imm & 32'hFFFF_F000);
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic do_req(input string tag, input bit [2:0] k, input bit [2:0] a,
                        input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [31:0] imm, input bit exp_ill, input bit [31:0] exp_w);
    kind_i = k; alu_i = a; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    valid_i = 1'b1;
    chk({tag, ".rdy_pre"}, 32'(ready_o), 32'd1);
    step();
    valid_i = 1'b0;
    chk({tag, ".rdy_enc"}, 32'(ready_o), 32'd0);
    chk({tag, ".we_enc"}, 32'(we_o), 32'd0);
    step();
    if (!exp_ill) begin
      chk({tag, ".we_wr"}, 32'(we_o), 32'd1);
      chk({tag, ".waddr"}, 32'(waddr_o), 32'(m_addr));
      chk({tag, ".wdata"}, wdata_o, exp_w);
      chk({tag, ".rdy_wr"}, 32'(ready_o), 32'd0);
      step();
      m_addr = (m_addr + 1) % CAP;
      m_cnt++;
      chk({tag, ".we_off"}, 32'(we_o), 32'd0);
    end else begin
      m_err = 1;
      chk({tag, ".we_ill"}, 32'(we_o), 32'd0);
    end
    chk({tag, ".count"}, 32'(count_o), 32'(m_cnt));
    chk({tag, ".addr_nx"}, 32'(waddr_o), 32'(m_addr));
    chk({tag, ".error"}, 32'(error_o), 32'(m_err));
    chk({tag, ".full"}, 32'(full_o), 32'(m_cnt == CAP));
    chk({tag, ".rdy_idle"}, 32'(ready_o), 32'(m_cnt != CAP));
  endtask

  task automatic do_model_req(input string tag, input bit [2:0] k, input bit [2:0] a,
                              input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                              input bit [31:0] imm);
    bit        ill;
    bit [31:0] w;
    ref_encode(32'(k), 32'(a), 32'(rd), 32'(rs1), 32'(rs2), imm, ill, w);
    do_req(tag, k, a, rd, rs1, rs2, imm, ill, w);
  endtask

  // clear asserted together with a valid request: the request must be dropped
  task automatic do_clear();
    clear_i = 1'b1;
    valid_i = 1'b1;
    kind_i = 3'd6; alu_i = 3'd0; rd_i = 5'd1; rs1_i = 5'd0; rs2_i = 5'd0; imm_i = 32'h1000;
    step();
    clear_i = 1'b0;
    valid_i = 1'b0;
    m_addr = 0; m_cnt = 0; m_err = 0;
    chk("clr.count", 32'(count_o), 32'd0);
    chk("clr.error", 32'(error_o), 32'd0);
    chk("clr.waddr", 32'(waddr_o), 32'd0);
    chk("clr.rdy", 32'(ready_o), 32'd1);
    chk("clr.we", 32'(we_o), 32'd0);
  endtask

  task automatic do_blocked();
    valid_i = 1'b1;
    kind_i = 3'd2; alu_i = 3'd0; rd_i = 5'd9; rs1_i = 5'd9; rs2_i = 5'd9; imm_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("blk.rdy", 32'(ready_o), 32'd0);
      step();
      chk("blk.we", 32'(we_o), 32'd0);
      chk("blk.count", 32'(count_o), 32'(CAP));
    end
    valid_i = 1'b0;
  endtask

  initial begin
    bit [2:0]  k, a;
    bit [31:0] imm;
    reset = 1'b1; valid_i = 1'b0; clear_i = 1'b0;
    kind_i = 3'd0; alu_i = 3'd0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0; imm_i = 32'd0;
    step();
    step();
    chk("rst.we", 32'(we_o), 32'd0);
    chk("rst.wdata", wdata_o, 32'd0);
    chk("rst.waddr", 32'(waddr_o), 32'd0);
    chk("rst.count", 32'(count_o), 32'd0);
    chk("rst.error", 32'(error_o), 32'd0);
    chk("rst.rdy", 32'(ready_o), 32'd1);
    chk("rst.full", 32'(full_o), 32'd0);
    reset = 1'b0;
    step();

    do_req("add", 3'd2, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h007302B3);
    do_req("sub", 3'd2, 3'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h403100B3);
    do_req("lw", 3'd0, 3'd0, 5'd4, 5'd2, 5'd0, 32'd8, 1'b0, 32'h00812203);
    do_clear();
    do_req("beq", 3'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, 32'hFE208CE3);
    do_req("jal", 3'd5, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 32'h010000EF);
    do_req("lui", 3'd6, 3'd0, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123451B7);
    do_req("beq_odd", 3'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 32'd0);
    do_req("kind7", 3'd7, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0);
    do_clear();

    // fill to capacity, then a fifth request must be ignored
    do_model_req("fill0", 3'd4, 3'd5, 5'd10, 5'd11, 5'd0, 32'hFFFF_F801);
    do_model_req("fill1", 3'd1, 3'd0, 5'd0, 5'd12, 5'd13, 32'hFFFF_FFFC);
    do_model_req("fill2", 3'd2, 3'd3, 5'd14, 5'd15, 5'd16, 32'd0);
    do_model_req("fill3", 3'd4, 3'd2, 5'd17, 5'd18, 5'd0, 32'h7FF);
    chk("full.flag", 32'(full_o), 32'd1);
    do_blocked();
    do_clear();
    do_model_req("after_clr", 3'd0, 3'd0, 5'd1, 5'd2, 5'd0, 32'd4);

    // reset while the encoder sits in ENC
    kind_i = 3'd6; alu_i = 3'd0; rd_i = 5'd7; rs1_i = 5'd0; rs2_i = 5'd0; imm_i = 32'hABCDE000;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("rstenc.rdy_enc", 32'(ready_o), 32'd0);
    reset = 1'b1;
    #1;
    chk("rstenc.we", 32'(we_o), 32'd0);
    chk("rstenc.wdata", wdata_o, 32'd0);
    chk("rstenc.waddr", 32'(waddr_o), 32'd0);
    chk("rstenc.count", 32'(count_o), 32'd0);
    chk("rstenc.error", 32'(error_o), 32'd0);
    chk("rstenc.rdy", 32'(ready_o), 32'd1);
    step();
    chk("rstenc.we_hold", 32'(we_o), 32'd0);
    reset = 1'b0;
    m_addr = 0; m_cnt = 0; m_err = 0;
    step();
    do_model_req("post_rst", 3'd2, 3'd5, 5'd8, 5'd9, 5'd10, 32'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) begin
        do_clear();
      end else if (m_cnt == CAP) begin
        do_blocked();
        do_clear();
      end else begin
        k = 3'($urandom_range(7));
        a = 3'($urandom_range(7));
        imm = $urandom;
        if ((k == 3'd3 || k == 3'd5) && $urandom_range(3) != 0) imm[0] = 1'b0;
        do_model_req("rand", k, a, 5'($urandom), 5'($urandom), 5'($urandom), imm);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
